// File: rtl/ahb_lite_master_arbiter.sv
// rtl/ahb_lite_master_arbiter.sv - two-master to one-slave AHB-Lite arbiter
//
// Puts two AHB-Lite masters onto one slave-side AHB-Lite port. Master 0 is the
// CPU and master 1 is a secondary bus master. Ownership of the address phase
// (gnt) and of the data phase (dph_owner) is tracked separately. A master that
// does not own the bus is held in its address phase with HREADY low. The bus
// changes hands only when the current owner is IDLE, unlocked, and the slave is
// ready.
//
// Ports:
//   HCLK, HRST                     clock, synchronous active-high reset
//   Mx_HADDR/HTRANS/HWRITE/HSIZE/
//   Mx_HBURST/HPROT/HMASTLOCK      master x address phase (x = 0, 1)
//   Mx_HWDATA                      master x write data
//   Mx_HRDATA                      read data, slave data broadcast to both
//   Mx_HREADY, Mx_HRESP            per-master ready and response
//   S_HADDR..S_HMASTLOCK           slave-side address phase (from gnt)
//   S_HWDATA                       slave write data (from data-phase owner)
//   S_HRDATA, S_HREADY, S_HRESP    slave read data, ready, response
//   HMASTER                        current address-phase owner
module ahb_lite_master_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter bit DEFAULT_MASTER = 1'b0
) (
    input  logic                  HCLK,
    input  logic                  HRST,
    input  logic [ADDR_WIDTH-1:0] M0_HADDR,
    input  logic [1:0]            M0_HTRANS,
    input  logic                  M0_HWRITE,
    input  logic [2:0]            M0_HSIZE,
    input  logic [2:0]            M0_HBURST,
    input  logic [3:0]            M0_HPROT,
    input  logic                  M0_HMASTLOCK,
    input  logic [DATA_WIDTH-1:0] M0_HWDATA,
    output logic [DATA_WIDTH-1:0] M0_HRDATA,
    output logic                  M0_HREADY,
    output logic                  M0_HRESP,
    input  logic [ADDR_WIDTH-1:0] M1_HADDR,
    input  logic [1:0]            M1_HTRANS,
    input  logic                  M1_HWRITE,
    input  logic [2:0]            M1_HSIZE,
    input  logic [2:0]            M1_HBURST,
    input  logic [3:0]            M1_HPROT,
    input  logic                  M1_HMASTLOCK,
    input  logic [DATA_WIDTH-1:0] M1_HWDATA,
    output logic [DATA_WIDTH-1:0] M1_HRDATA,
    output logic                  M1_HREADY,
    output logic                  M1_HRESP,
    output logic [ADDR_WIDTH-1:0] S_HADDR,
    output logic [1:0]            S_HTRANS,
    output logic                  S_HWRITE,
    output logic [2:0]            S_HSIZE,
    output logic [2:0]            S_HBURST,
    output logic [3:0]            S_HPROT,
    output logic                  S_HMASTLOCK,
    output logic [DATA_WIDTH-1:0] S_HWDATA,
    input  logic [DATA_WIDTH-1:0] S_HRDATA,
    input  logic                  S_HREADY,
    input  logic                  S_HRESP,
    output logic                  HMASTER
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    logic gnt_q, gnt_d;
    logic dph_owner_q, dph_owner_d;
    logic dph_valid_q, dph_valid_d;

    // Address-phase view of the current owner and request from the other side.
    logic [1:0] own_htrans;
    logic       own_hmastlock;
    logic       oth_req;
    logic       handover;

    always_comb begin
        own_htrans    = gnt_q ? M1_HTRANS    : M0_HTRANS;
        own_hmastlock = gnt_q ? M1_HMASTLOCK : M0_HMASTLOCK;
        oth_req       = gnt_q ? M0_HTRANS[1] : M1_HTRANS[1];
        // Safe switch point: owner's address phase is IDLE and unlocked, and
        // the slave is accepting it, so no burst or locked sequence is split.
        handover      = S_HREADY && (own_htrans == HTRANS_IDLE) &&
                        !own_hmastlock && oth_req;
    end

    // State register
    always_ff @(posedge HCLK) begin
        if (HRST) begin
            gnt_q       <= DEFAULT_MASTER;
            dph_owner_q <= DEFAULT_MASTER;
            dph_valid_q <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            dph_owner_q <= dph_owner_d;
            dph_valid_q <= dph_valid_d;
        end
    end

    // Next state: data-phase registers advance only when the slave accepts
    // the current address phase; otherwise everything holds (wait state).
    always_comb begin
        gnt_d       = gnt_q;
        dph_owner_d = dph_owner_q;
        dph_valid_d = dph_valid_q;
        if (S_HREADY) begin
            dph_owner_d = gnt_q;
            dph_valid_d = own_htrans[1];
            if (handover) begin
                gnt_d = ~gnt_q;
            end
        end
    end

    // Outputs
    logic dph_live;

    always_comb begin
        // During reset the data phase is abandoned, so only gnt keeps a ready.
        dph_live = dph_valid_q && !HRST;

        HMASTER     = gnt_q;
        S_HADDR     = gnt_q ? M1_HADDR  : M0_HADDR;
        S_HWRITE    = gnt_q ? M1_HWRITE : M0_HWRITE;
        S_HSIZE     = gnt_q ? M1_HSIZE  : M0_HSIZE;
        S_HBURST    = gnt_q ? M1_HBURST : M0_HBURST;
        S_HPROT     = gnt_q ? M1_HPROT  : M0_HPROT;
        S_HTRANS    = HRST ? HTRANS_IDLE : own_htrans;
        S_HMASTLOCK = HRST ? 1'b0 : own_hmastlock;

        S_HWDATA    = dph_owner_q ? M1_HWDATA : M0_HWDATA;
        M0_HRDATA   = S_HRDATA;
        M1_HRDATA   = S_HRDATA;

        M0_HREADY   = S_HREADY && (!gnt_q || (dph_live && !dph_owner_q));
        M1_HREADY   = S_HREADY && ( gnt_q || (dph_live &&  dph_owner_q));

        M0_HRESP    = S_HRESP && dph_live && !dph_owner_q;
        M1_HRESP    = S_HRESP && dph_live &&  dph_owner_q;
    end

endmodule
